// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO result registers
module muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        MoveTo,
  input  logic [2:0]  Sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  localparam logic [2:0] SEL_MUL  = 3'd1;
  localparam logic [2:0] SEL_MULU = 3'd2;
  localparam logic [2:0] SEL_DIV  = 3'd3;
  localparam logic [2:0] SEL_DIVU = 3'd4;
  localparam logic [2:0] SEL_HI   = 3'd5;
  localparam logic [2:0] SEL_LO   = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [2:0]       r_op;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic        w_start_ok;
  logic        w_is_div;
  logic        w_is_signed_mul;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_write_result;

  // Only the four arithmetic codes launch an operation; anything else is a no-op.
  assign w_start_ok      = Start && (Sel >= SEL_MUL) && (Sel <= SEL_DIVU);
  assign w_is_div        = (r_op == SEL_DIV) || (r_op == SEL_DIVU);
  assign w_is_signed_mul = (r_op == SEL_MUL);

  // Full 64-bit products from the latched operands.
  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide is done on magnitudes then re-signed; this makes
  // 0x80000000 / -1 wrap to 0x80000000 with remainder 0 without special casing.
  assign w_a_neg   = (r_op == SEL_DIV) && r_a[31];
  assign w_b_neg   = (r_op == SEL_DIV) && r_b[31];
  assign w_a_mag   = w_a_neg ? (~r_a + 32'd1) : r_a;
  assign w_b_mag   = w_b_neg ? (~r_b + 32'd1) : r_b;
  assign w_quo_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
  assign w_rem_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
  assign w_quo     = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
  assign w_rem     = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

  assign w_res_hi = w_is_div ? w_rem :
                    (w_is_signed_mul ? w_prod_s[63:32] : w_prod_u[63:32]);
  assign w_res_lo = w_is_div ? w_quo :
                    (w_is_signed_mul ? w_prod_s[31:0] : w_prod_u[31:0]);

  // Divide by zero still burns the full latency but leaves HI/LO untouched.
  assign w_write_result = !(w_is_div && (r_b == 32'd0));

  // Control FSM: accept start/move in IDLE, count down in BUSY, commit result on the last busy edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 3'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= Sel;
            r_cnt   <= (Sel <= SEL_MULU) ? MUL_LOAD : DIV_LOAD;
            r_busy  <= 1'b1;
            r_state <= BUSY;
          end else if (MoveTo) begin
            if (Sel == SEL_HI) begin
              r_hi <= A;
            end else if (Sel == SEL_LO) begin
              r_lo <= A;
            end
          end
        end
        BUSY: begin
          if (r_cnt <= CNT_W'(1)) begin
            if (w_write_result) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Out  = (Sel == SEL_HI) ? r_hi :
                (Sel == SEL_LO) ? r_lo : 32'd0;

endmodule
